// File: rtl/mmcam_pair_fifo.sv
// Operand-pair FIFO behind the MMCAM matching entries: orders a fired pair into
// left/right (or queues a single operand) and hands packets downstream by valid/ready.
module mmcam_pair_fifo #(
  parameter int CGD_W  = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                         CP,
  input  logic                         MR,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CGD_W-1:0]             in_cgd,
  input  logic                         in_lr,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_single,
  input  logic                         match_fire,
  input  logic [DATA_W-1:0]            match_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CGD_W-1:0]             out_cgd,
  output logic [DATA_W-1:0]            out_left,
  output logic [DATA_W-1:0]            out_right,
  output logic                         out_single,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CGD_W-1:0]  r_mem_cgd    [DEPTH];
  logic [DATA_W-1:0] r_mem_left   [DEPTH];
  logic [DATA_W-1:0] r_mem_right  [DEPTH];
  logic              r_mem_single [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_proto_err;

  logic              w_accept;
  logic              w_pop;
  logic              w_push;
  logic [DATA_W-1:0] w_push_left;
  logic [DATA_W-1:0] w_push_right;
  logic              w_push_single;
  logic              w_err;

  assign in_ready  = (r_count != CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_accept  = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // A fire without a token, or a fire on a single-operand token, is an upstream fault.
  assign w_err = (match_fire & ~in_valid) | (match_fire & in_single & w_accept);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_push        = 1'b0;
    w_push_left   = in_data;
    w_push_right  = '0;
    w_push_single = 1'b0;
    if (w_accept) begin
      if (in_single) begin
        w_push        = 1'b1;
        w_push_single = 1'b1;
      end else if (match_fire) begin
        w_push = 1'b1;
        if (in_lr) begin
          w_push_left  = match_data;
          w_push_right = in_data;
        end else begin
          w_push_right = match_data;
        end
      end
    end
  end

  // NOTE: packet storage has no reset; the count and pointers alone decide what is valid.
  always_ff @(posedge CP) begin
    if (w_push) begin
      r_mem_cgd[r_wr_ptr]    <= in_cgd;
      r_mem_left[r_wr_ptr]   <= w_push_left;
      r_mem_right[r_wr_ptr]  <= w_push_right;
      r_mem_single[r_wr_ptr] <= w_push_single;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_err) r_proto_err <= 1'b1;
    end
  end

  // Head fields read as zero while empty, which also gives the zeroed outputs under reset.
  assign out_cgd    = out_valid ? r_mem_cgd[r_rd_ptr]    : '0;
  assign out_left   = out_valid ? r_mem_left[r_rd_ptr]   : '0;
  assign out_right  = out_valid ? r_mem_right[r_rd_ptr]  : '0;
  assign out_single = out_valid ? r_mem_single[r_rd_ptr] : 1'b0;
  assign count      = r_count;
  assign proto_err  = r_proto_err;

endmodule
